// File: rtl/mcu_bus_regfile.sv
// Asynchronous MCU parallel-bus slave: synchronised strobes, IDLE/WR/RD FSM, NREG x DW control registers.
// Optional glitch filter on strobe entry enabled by defining MCU_GLITCH_FILT_EN.
module mcu_bus_regfile #(
    parameter int              AW          = 4,
    parameter int              DW          = 8,
    parameter int              NREG        = 16,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DW-1:0]   RST_VAL     = '0,
    parameter int              FILT_CYC    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mcu_cs_n,
    input  logic                 mcu_wr_n,
    input  logic                 mcu_rd_n,
    input  logic [AW-1:0]        mcu_addr,
    input  logic [DW-1:0]        mcu_db_in,
    output logic [DW-1:0]        mcu_db_out,
    output logic                 mcu_db_oe,
    output logic [NREG*DW-1:0]   reg_q,
    output logic [NREG-1:0]      wr_pulse,
    output logic                 err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [AW-1:0]          r_addr;
    logic [DW-1:0]          r_data;
    logic                   r_commit;
    logic [NREG*DW-1:0]     r_reg_q;
    logic [NREG-1:0]        r_wr_pulse;
    logic                   r_err_addr;
    logic [DW-1:0]          r_db_out;
    logic                   r_db_oe;
    logic                   w_wr_act;
    logic                   w_rd_act;
    logic                   w_commit;
    logic                   w_filt_ok;
    logic [NREG-1:0]        w_wr_sel;
    logic                   w_mapped;
    logic [DW-1:0]          w_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync <= '1;
            r_wr_sync <= '1;
            r_rd_sync <= '1;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], mcu_cs_n};
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], mcu_wr_n};
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], mcu_rd_n};
        end
    end

    assign w_wr_act = ~r_cs_sync[SYNC_STAGES-1] & ~r_wr_sync[SYNC_STAGES-1];
    assign w_rd_act = ~r_cs_sync[SYNC_STAGES-1] & ~r_rd_sync[SYNC_STAGES-1];

`ifdef MCU_GLITCH_FILT_EN
    localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    logic [CW-1:0] r_filt_cnt;
    logic          w_filt_cond;

    assign w_filt_cond = (r_state == S_IDLE) && (w_wr_act || w_rd_act);
    assign w_filt_ok   = (r_filt_cnt == CW'(FILT_CYC - 1));

    // Saturating count of consecutive cycles the entry condition has held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_filt_cnt <= '0;
        else if (!w_filt_cond)
            r_filt_cnt <= '0;
        else if (!w_filt_ok)
            r_filt_cnt <= r_filt_cnt + 1'b1;
    end
`else
    assign w_filt_ok = (FILT_CYC >= 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_filt_ok && w_wr_act)
                    w_state_nxt = S_WR;
                else if (w_filt_ok && w_rd_act)
                    w_state_nxt = S_RD;
            end
            S_WR: begin
                if (!w_wr_act) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
            S_RD: begin
                if (!w_rd_act || w_wr_act)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_sel  = '0;
        w_rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            w_wr_sel[i] = (r_addr == AW'(i));
            if (mcu_addr == AW'(i))
                w_rd_data = r_reg_q[i*DW +: DW];
        end
    end

    assign w_mapped = |w_wr_sel;

    // Commit lands one cycle after the FSM leaves WR, with the pulse aligned to the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_commit   <= 1'b0;
            r_reg_q    <= {NREG{RST_VAL}};
            r_wr_pulse <= '0;
            r_err_addr <= 1'b0;
            r_db_out   <= '0;
            r_db_oe    <= 1'b0;
        end else begin
            if (r_state == S_WR) begin
                r_addr <= mcu_addr;
                r_data <= mcu_db_in;
            end
            r_commit   <= w_commit;
            r_wr_pulse <= r_commit ? w_wr_sel : '0;
            r_err_addr <= r_commit & ~w_mapped;
            if (r_commit) begin
                for (int i = 0; i < NREG; i++)
                    if (w_wr_sel[i])
                        r_reg_q[i*DW +: DW] <= r_data;
            end
            if (r_state == S_RD)
                r_db_out <= w_rd_data;
            r_db_oe <= (r_state == S_RD) && (w_state_nxt == S_RD);
        end
    end

    assign reg_q      = r_reg_q;
    assign wr_pulse   = r_wr_pulse;
    assign err_addr   = r_err_addr;
    assign mcu_db_out = r_db_out;
    assign mcu_db_oe  = r_db_oe;

endmodule
